nibble_serial_subtractor: RTL
=============================

Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor: diff = a - b, one SLICE-bit slice per clock, LSB slice first, borrow chained between slices in a register.
- Inverse-operation companion to the team's combinational nibble-slice adder.
- Targets area-constrained datapaths: one SLICE-bit adder slice is reused instead of WIDTH/SLICE instances.
- Valid/ready handshake on both the operand input side and the result output side.

Parameters:
- WIDTH, 32, operand and result width. Must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle.
- NSLICE, WIDTH/SLICE (derived localparam, 8 by default), cycles spent in RUN.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- in_a  input  WIDTH  minuend
- in_b  input  WIDTH  subtrahend
- out_valid  output  1  result held valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- out_diff  output  WIDTH  a - b modulo 2^WIDTH
- out_borrow  output  1  unsigned borrow (a < b)
- out_overflow  output  1  signed two's-complement overflow
- out_zero  output  1  out_diff == 0
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset are decided: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset state: IDLE.
  - Outputs after reset: in_ready=1, out_valid=0, out_diff=0, out_borrow=0, out_overflow=0, out_zero=0, busy=0.
  - Internal registers after reset: slice counter 0, carry register 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch in_a, and ~in_b into the operand registers; set carry=1 (two's-complement add); counter=0; go to RUN.
  - in_a/in_b are ignored at all other times.
- RUN:
  - in_ready=0.
  - Each edge: slice sum = a_slice + nb_slice + carry. The SLICE-bit sum is shifted into the result register from the MSB end, and carry takes the slice carry-out. Operand registers shift right by SLICE. Counter increments.
  - On the edge that processes slice NSLICE-1, go to DONE.
  - The sign bits of a and ~b are captured during the top slice for the overflow computation.
- DONE:
  - out_valid=1.
  - Outputs are stable and held for any number of cycles while out_ready=0.
  - out_borrow = ~final carry.
  - out_overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - out_zero = (out_diff == 0), evaluated on the value actually driven.
  - On out_valid&&out_ready at an edge: go to IDLE. out_diff and flags keep their last values; out_valid is cleared.
- Latency: operands accepted at edge k, out_valid=1 after edge k+NSLICE (8 cycles by default).
- Minimum initiation interval: NSLICE+2 cycles. There is no accept in the same cycle as a result handshake.
- in_valid is ignored in RUN and DONE. No operand queueing.
- out_ready is ignored outside DONE.
- Reset mid-operation (RUN or DONE) aborts: next cycle in IDLE with all reset values; no result is emitted.
- Arithmetic wraps modulo 2^WIDTH. Equal operands give 0 with borrow=0.

Optional Feature:
- Macro: NIBBLE_SUB_SATURATE_EN.
- Defined: unsigned saturation. When the final borrow=1, out_diff is forced to 0 and out_zero=1. out_borrow=1 still reports the underflow. out_overflow is computed from the unsaturated result.
- Undefined: pure modulo result as described in Behaviour. No saturation logic is synthesized.

Test Plan:
- Basic subtract: a=0x00000005, b=0x00000003 -> out_valid 8 cycles after accept; diff=0x00000002, borrow=0, overflow=0, zero=0.
- Unsigned underflow: a=0, b=1.
  - Without macro: diff=0xFFFFFFFF, borrow=1, overflow=0, zero=0.
  - With NIBBLE_SUB_SATURATE_EN: diff=0x00000000, borrow=1, zero=1.
- Signed overflow: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, overflow=1, borrow=0.
- Equal operands: a=b=0x12345678 -> diff=0, zero=1, borrow=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands.
  - During the hold: outputs constant, in_ready=0, new operands not taken.
  - After out_ready=1 for one edge: IDLE, in_ready=1 next cycle; the next op completes correctly.
- Reset mid-RUN: assert rst for one cycle on RUN cycle 3 of a=0xFFFFFFFF, b=0x1 -> next cycle IDLE, in_ready=1, out_valid=0, outputs zero; out_valid never asserts for that op.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Slice-serial WIDTH-bit subtractor: diff = a - b, SLICE bits per clock, LSB slice first.
// Optional unsigned saturation on underflow when NIBBLE_SUB_SATURATE_EN is defined.
module nibble_serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one slice added per clock, NSLICE clocks
    // DONE  | result presented, held until out_ready

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] fin_diff;
    logic             final_borrow;
    logic             sign_a;
    logic             sign_b;
    logic             ovf_raw;

    // a - b computed as a + ~b + 1; the +1 is the initial carry.
    assign slice_sum    = {1'b0, a_q[SLICE-1:0]} + {1'b0, nb_q[SLICE-1:0]}
                        + {{SLICE{1'b0}}, carry_q};
    assign res_shift    = (res_q >> SLICE)
                        | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
    assign final_borrow = ~slice_sum[SLICE];

    // Operands shift right, so during the top slice their sign bits sit at SLICE-1.
    assign sign_a  = a_q[SLICE-1];
    assign sign_b  = ~nb_q[SLICE-1];
    assign ovf_raw = (sign_a != sign_b) && (res_shift[WIDTH-1] != sign_a);

`ifdef NIBBLE_SUB_SATURATE_EN
    assign fin_diff = final_borrow ? '0 : res_shift;
`else
    assign fin_diff = res_shift;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        nb_d     = nb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    nb_d    = ~in_b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = res_shift;
                carry_d = slice_sum[SLICE];
                a_d     = a_q >> SLICE;
                nb_d    = nb_q >> SLICE;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    diff_d   = fin_diff;
                    borrow_d = final_borrow;
                    ovf_d    = ovf_raw;
                    zero_d   = (fin_diff == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            nb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign out_diff     = diff_q;
    assign out_borrow   = borrow_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;

endmodule
